// File: rtl/sd_cmd_tx_pkg.sv
// Shared SD definitions: CRC7, frame length and command-TX state encoding.
// The response receiver reuses sd_crc7_40 for its own CRC check.
package sd_cmd_tx_pkg;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int         FRAME_LEN = 48;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } sd_state_e;

  // Zero-seed CRC7 (x^7+x^3+1) over 40 bits, MSB first.
  function automatic logic [6:0] sd_crc7_40(
    input logic [39:0] d
  );
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    return c;
  endfunction

  function automatic logic [47:0] sd_cmd_frame(
    input logic [5:0]  index,
    input logic [31:0] arg
  );
    logic [39:0] head;
    head = {2'b01, index, arg};
    return {head, sd_crc7_40(head), 1'b1};
  endfunction

endpackage

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: shifts out 48-bit command frames on falling
// SD clock strobes, then holds the line idle for NGAP SD clocks.
module sd_cmd_tx
  import sd_cmd_tx_pkg::*;
#(
  parameter int NGAP = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ckstb,
  input  logic        i_hlfck,
  input  logic [7:0]  i_ckspd,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_index,
  input  logic [31:0] i_arg,
  output logic        o_cmd_en,
  output logic [1:0]  o_cmd_data,
  output logic        o_done
);

  localparam int GW = $clog2(NGAP + 2) + 1;

  sd_state_e       state_q, state_d;
  logic [47:0]     sr_q, sr_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            en_q, en_d;
  logic [1:0]      dat_q, dat_d;
  logic            done_q, done_d;
  logic            two;

  // Rising-edge strobe is not needed: all CMD changes follow hlfck.
  logic unused_ckstb;
  assign unused_ckstb = i_ckstb;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      en_q    <= 1'b0;
      dat_q   <= 2'b11;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    en_d    = en_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    two     = (i_ckspd == 8'd0);
    unique case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        dat_d = 2'b11;
        gap_d = '0;
        if (i_valid) begin
          sr_d    = sd_cmd_frame(i_index, i_arg);
          cnt_d   = 6'(FRAME_LEN);
          state_d = SEND;
        end
      end
      SEND: begin
        if (i_hlfck) begin
          en_d = 1'b1;
          // A lone trailing bit is always sent single even at full speed.
          if (two && cnt_q >= 6'd2) begin
            dat_d = sr_q[47:46];
            sr_d  = {sr_q[45:0], 2'b00};
            cnt_d = cnt_q - 6'd2;
          end else begin
            dat_d = {2{sr_q[47]}};
            sr_d  = {sr_q[46:0], 1'b0};
            cnt_d = cnt_q - 6'd1;
          end
          if (cnt_d == 6'd0) state_d = GAP;
        end
      end
      GAP: begin
        if (i_hlfck) begin
          en_d  = 1'b0;
          dat_d = 2'b11;
          gap_d = gap_q + GW'(two ? 2 : 1);
          if (gap_d >= GW'(NGAP)) begin
            gap_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready    = (state_q == IDLE);
  assign o_cmd_en   = en_q;
  assign o_cmd_data = dat_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: strobe generator, bit-collecting monitor and
// an expected-frame queue checked per scenario.
module tb_sd_cmd_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ckstb = 1'b0;
  logic        hlfck = 1'b0;
  logic [7:0]  ckspd = 8'd0;
  logic        valid = 1'b0;
  logic [5:0]  idx = '0;
  logic [31:0] arg = '0;
  logic        ready, cmd_en, done;
  logic [1:0]  cmd_data;

  int checks = 0;
  int errors = 0;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  int          ev_q[$];
  int          gap_q[$];
  int          idle_q[$];

  int          split_err = 0;
  int          done_cnt = 0;
  int          nbits = 0;
  logic [7:0]  spd_req = 8'd3;
  int          div = 0;

  sd_cmd_tx #(.NGAP(8)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_ckstb    (ckstb),
    .i_hlfck    (hlfck),
    .i_ckspd    (ckspd),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_index    (idx),
    .i_arg      (arg),
    .o_cmd_en   (cmd_en),
    .o_cmd_data (cmd_data),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Clock-generator model: speed only changes at an SD clock boundary.
  initial forever begin
    @(negedge clk);
    if (div == 0) ckspd = spd_req;
    if (ckspd <= 8'd1) begin
      hlfck = 1'b1;
      ckstb = 1'b1;
      div   = 0;
    end else begin
      hlfck = (div == int'(ckspd) - 1);
      ckstb = (div == int'(ckspd) / 2 - 1);
      div   = hlfck ? 0 : div + 1;
    end
  end

  // Monitor: rebuild frames from CMD bits following each hlfck.
  logic [47:0] bits = '0;
  logic        m_hl;
  logic [7:0]  m_sp;
  int          cyc = 0;
  int          first_cyc = 0;
  int          idle_ev = 0;
  bit          after = 1'b0;

  initial forever begin
    @(posedge clk);
    m_hl = hlfck;
    m_sp = ckspd;
    cyc++;
    #1;
    if (!rst_n) begin
      nbits = 0;
      after = 1'b0;
      idle_ev = 0;
    end else begin
      if (m_hl && cmd_en) begin
        if (nbits == 0) begin
          if (after) idle_q.push_back(idle_ev);
          after = 1'b0;
          first_cyc = cyc;
        end
        if (m_sp == 8'd0) begin
          bits = {bits[45:0], cmd_data};
          nbits += 2;
        end else begin
          if (cmd_data[1] !== cmd_data[0]) split_err++;
          bits = {bits[46:0], cmd_data[1]};
          nbits += 1;
        end
        if (nbits >= 48) begin
          obs_q.push_back(bits);
          ev_q.push_back(cyc - first_cyc + 1);
          nbits = 0;
          after = 1'b1;
          idle_ev = 0;
        end
      end else if (m_hl && after) begin
        idle_ev++;
      end
      if (done) begin
        done_cnt++;
        gap_q.push_back(idle_ev);
      end
    end
  end

  function automatic logic [47:0] ref_frame(
    input logic [5:0]  i,
    input logic [31:0] a
  );
    logic [46:0] r;
    logic [39:0] m;
    m = {2'b01, i, a};
    r = {m, 7'b0};
    for (int k = 46; k >= 7; k--)
      if (r[k]) r[k-:8] = r[k-:8] ^ 8'h89;
    return {m, r[6:0], 1'b1};
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = ready;
  endtask

  task automatic issue(
    input logic [5:0]  i,
    input logic [31:0] a,
    input logic [47:0] f
  );
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_wait got=0 want=1");
    end
    idx = i;
    arg = a;
    valid = 1'b1;
    exp_q.push_back(f);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_frame(output logic [47:0] o, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (obs_q.size() != 0);
    o = ok ? obs_q.pop_front() : '0;
  endtask

  task automatic wait_gap(output int g, output bit ok);
    int n = 0;
    while (gap_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (gap_q.size() != 0);
    g = ok ? gap_q.pop_front() : -1;
  endtask

  function automatic logic [47:0] pop_exp();
    return (exp_q.size() != 0) ? exp_q.pop_front() : '1;
  endfunction

  task automatic clear_q();
    ev_q.delete();
    gap_q.delete();
    idle_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got=%b want=1", ready);
    end
    checks++;
    if (cmd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_en got=%b want=0", cmd_en);
    end
    checks++;
    if (cmd_data !== 2'b11) begin
      errors++;
      $display("FAIL rst_data got=%b want=11", cmd_data);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b want=0", done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd0();
    logic [47:0] o, e;
    bit ok;
    int g;
    spd_req = 8'd3;
    repeat (6) @(negedge clk);
    clear_q();
    issue(6'd0, 32'h0, 48'h400000000095);
    wait_frame(o, ok);
    e = pop_exp();
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL cmd0_frame got=%h want=%h", o, e);
    end
    wait_gap(g, ok);
    checks++;
    if (g != 8) begin
      errors++;
      $display("FAIL cmd0_gap got=%0d want=8", g);
    end
    checks++;
    if (split_err != 0) begin
      errors++;
      $display("FAIL cmd0_split got=%0d want=0", split_err);
    end
  endtask

  task automatic test_cmd8();
    logic [47:0] o, e;
    bit ok;
    int g, ev;
    spd_req = 8'd0;
    repeat (6) @(negedge clk);
    clear_q();
    issue(6'd8, 32'h1AA, 48'h48000001AA87);
    wait_frame(o, ok);
    e = pop_exp();
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL cmd8_frame got=%h want=%h", o, e);
    end
    ev = (ev_q.size() != 0) ? ev_q.pop_front() : -1;
    checks++;
    if (ev != 24) begin
      errors++;
      $display("FAIL cmd8_cycles got=%0d want=24", ev);
    end
    wait_gap(g, ok);
    checks++;
    if (g != 4) begin
      errors++;
      $display("FAIL cmd8_gap got=%0d want=4", g);
    end
  endtask

  task automatic test_cmd17();
    logic [47:0] o, e;
    bit ok;
    int n, ev;
    spd_req = 8'd1;
    repeat (6) @(negedge clk);
    clear_q();
    issue(6'd17, 32'h00001000, ref_frame(6'd17, 32'h00001000));
    n = 0;
    while (!ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 56) begin
      errors++;
      $display("FAIL cmd17_busy got=%0d want=56", n);
    end
    wait_frame(o, ok);
    e = pop_exp();
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL cmd17_frame got=%h want=%h", o, e);
    end
    ev = (ev_q.size() != 0) ? ev_q.pop_front() : -1;
    checks++;
    if (ev != 48) begin
      errors++;
      $display("FAIL cmd17_cycles got=%0d want=48", ev);
    end
    checks++;
    if (split_err != 0) begin
      errors++;
      $display("FAIL cmd17_split got=%0d want=0", split_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] o, e;
    bit ok;
    int n, rh, il;
    logic rd;
    spd_req = 8'd2;
    wait_ready(ok);
    clear_q();
    idx = 6'd5;
    arg = 32'hCAFE0001;
    valid = 1'b1;
    exp_q.push_back(ref_frame(6'd5, 32'hCAFE0001));
    @(negedge clk);
    idx = 6'd6;
    arg = 32'h0BADF00D;
    exp_q.push_back(ref_frame(6'd6, 32'h0BADF00D));
    n = 0;
    rh = 0;
    while (!done && n < 2000) begin
      if (ready) rh++;
      @(negedge clk);
      n++;
    end
    rd = ready;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (rh != 0) begin
      errors++;
      $display("FAIL b2b_ready_busy got=%0d want=0", rh);
    end
    checks++;
    if (rd !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_ready got=%b want=1", rd);
    end
    for (int k = 0; k < 2; k++) begin
      wait_frame(o, ok);
      e = pop_exp();
      checks++;
      if (!ok || o !== e) begin
        errors++;
        $display("FAIL b2b_frame%0d got=%h want=%h", k, o, e);
      end
    end
    il = (idle_q.size() != 0) ? idle_q[idle_q.size() - 1] : -1;
    checks++;
    if (il != 8) begin
      errors++;
      $display("FAIL b2b_idle got=%0d want=8", il);
    end
  endtask

  task automatic test_speed_switch();
    logic [47:0] o, e;
    bit ok;
    int n;
    spd_req = 8'd4;
    repeat (10) @(negedge clk);
    clear_q();
    issue(6'd17, 32'h0, 48'h510000000055);
    n = 0;
    while (nbits < 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    spd_req = 8'd2;
    wait_frame(o, ok);
    e = pop_exp();
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL speed_frame got=%h want=%h", o, e);
    end
    checks++;
    if (split_err != 0) begin
      errors++;
      $display("FAIL speed_split got=%0d want=0", split_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] o, e;
    bit ok;
    int n, d0;
    spd_req = 8'd2;
    repeat (6) @(negedge clk);
    clear_q();
    issue(6'd1, 32'hDEADBEEF, ref_frame(6'd1, 32'hDEADBEEF));
    n = 0;
    while (nbits < 30 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_en got=%b want=0", cmd_en);
    end
    checks++;
    if (cmd_data !== 2'b11) begin
      errors++;
      $display("FAIL mid_rst_data got=%b want=11", cmd_data);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_ready got=%b want=1", ready);
    end
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL mid_rst_done got=%0d want=%0d", done_cnt, d0);
    end
    issue(6'd2, 32'h12345678, ref_frame(6'd2, 32'h12345678));
    wait_frame(o, ok);
    e = pop_exp();
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL mid_rst_next got=%h want=%h", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_cmd17();
    test_back_to_back();
    test_speed_switch();
    test_reset_mid();
    repeat (50) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
